// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command controller: opcodes, frame lengths, FSM states.
// Define SPI_CMD_AUTOINC_EN to enable the *_NEXT opcodes and the auto-increment address register.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    OP_WRITE_AT   = 3'b000,
    OP_READ_AT    = 3'b001,
    OP_WRITE_NEXT = 3'b010,
    OP_READ_NEXT  = 3'b011
  } opcode_t;

  localparam logic [2:0] LEN_WRITE_AT   = 3'd4;
  localparam logic [2:0] LEN_READ_AT    = 3'd3;
  localparam logic [2:0] LEN_WRITE_NEXT = 3'd2;
  localparam logic [2:0] LEN_READ_NEXT  = 3'd1;
  localparam logic [2:0] LEN_INVALID    = 3'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    BUS     = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

  function automatic logic op_valid(input logic [2:0] op);
`ifdef SPI_CMD_AUTOINC_EN
    return (op[2] == 1'b0);
`else
    return (op == OP_WRITE_AT) || (op == OP_READ_AT);
`endif
  endfunction

  function automatic logic [2:0] op_length(input logic [2:0] op);
    logic [2:0] len;
    len = LEN_INVALID;
    case (op)
      OP_WRITE_AT:   len = LEN_WRITE_AT;
      OP_READ_AT:    len = LEN_READ_AT;
`ifdef SPI_CMD_AUTOINC_EN
      OP_WRITE_NEXT: len = LEN_WRITE_NEXT;
      OP_READ_NEXT:  len = LEN_READ_NEXT;
`endif
      default:       len = LEN_INVALID;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/spi_cmd_controller_sync2.sv
// Two-flop synchroniser with asynchronous active-high reset to 0.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/spi_cmd_controller.sv
// Turns each completed SPI command frame into one 8-bit bus cycle; read data becomes the next frame's first MISO byte.
// Optional SPI_CMD_AUTOINC_EN adds *_NEXT opcodes using an auto-incrementing address register.
module spi_cmd_controller
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  output logic              buf_reset,
  input  logic [31:0]       buf_rx,       // byte n of the frame at [8n+7:8n]
  input  logic              buf_valid,
  output logic [2:0]        buf_length,
  output logic [DATA_W-1:0] buf_tx_byte,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              cmd_err
);

  logic [7:0]        w_b0, w_b1, w_b2, w_b3;
  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_at_addr;
  logic              w_valid_s;
  logic              w_cs_s;
  logic              w_valid_rise;
  logic              w_unused;

  state_t            r_state;
  logic              r_valid_prev;
`ifdef SPI_CMD_AUTOINC_EN
  logic [ADDR_W-1:0] r_addr;
`endif

  assign w_b0 = buf_rx[7:0];
  assign w_b1 = buf_rx[15:8];
  assign w_b2 = buf_rx[23:16];
  assign w_b3 = buf_rx[31:24];
  assign w_op = w_b0[7:5];
  assign w_unused = ^w_b0[4:0];

  // WRITE_AT carries data before the address; READ_AT has the address right after the opcode.
  assign w_at_addr = (w_op == OP_READ_AT) ? ADDR_W'({w_b1, w_b2}) : ADDR_W'({w_b2, w_b3});

  assign buf_reset  = reset | spi_cs_n;
  assign buf_length = op_length(w_op);
  assign busy       = (r_state == DECODE) || (r_state == BUS);

  sync2 u_sync_valid (.clk(clk), .reset(reset), .i_d(buf_valid), .o_q(w_valid_s));
  sync2 u_sync_cs    (.clk(clk), .reset(reset), .i_d(spi_cs_n),  .o_q(w_cs_s));

  assign w_valid_rise = w_valid_s & ~r_valid_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_valid_prev <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      buf_tx_byte  <= '0;
      cmd_err      <= 1'b0;
`ifdef SPI_CMD_AUTOINC_EN
      r_addr       <= '0;
`endif
    end else begin
      r_valid_prev <= w_valid_s;
      cmd_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid_rise) r_state <= DECODE;
        end
        DECODE: begin
          if (op_valid(w_op)) begin
            bus_req   <= 1'b1;
            bus_we    <= ~w_op[0];
            bus_wdata <= DATA_W'(w_b1);
`ifdef SPI_CMD_AUTOINC_EN
            bus_addr  <= w_op[1] ? r_addr : w_at_addr;
`else
            bus_addr  <= w_at_addr;
`endif
            r_state   <= BUS;
          end else begin
            cmd_err   <= 1'b1;
            r_state   <= WAIT_CS;
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) buf_tx_byte <= bus_rdata;
`ifdef SPI_CMD_AUTOINC_EN
            r_addr  <= bus_addr + 1'b1;
`endif
            r_state <= WAIT_CS;
          end
        end
        WAIT_CS: begin
          if (w_cs_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Self-checking bench for spi_cmd_controller: scoreboard of expected bus cycles popped as the DUT issues them.
module tb_spi_cmd_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs_n;
  logic        buf_reset;
  logic [31:0] buf_rx;
  logic        buf_valid;
  logic [2:0]  buf_length;
  logic [7:0]  buf_tx_byte;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        busy;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  // {we, addr, wdata}
  logic [24:0] exp_q[$];

  always #5 clk = ~clk;

  spi_cmd_controller #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .buf_reset(buf_reset),
    .buf_rx(buf_rx), .buf_valid(buf_valid), .buf_length(buf_length),
    .buf_tx_byte(buf_tx_byte), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .busy(busy), .cmd_err(cmd_err)
  );

  task automatic begin_frame(input logic [31:0] rx);
    @(negedge clk);
    spi_cs_n  = 1'b0;
    buf_valid = 1'b0;
    buf_rx    = rx;
    @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    buf_valid = 1'b0;
    spi_cs_n  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Waits (bounded) for bus_req, captures the fields, then acks after 'hold' cycles.
  task automatic bus_cycle(input int hold, input logic [7:0] rdata,
                           output logic ok, output logic [24:0] obs);
    ok  = 1'b0;
    obs = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      obs = {bus_we, bus_addr, bus_wdata};
      repeat (hold) @(negedge clk);
      bus_ack   = 1'b1;
      bus_rdata = rdata;
      @(negedge clk);
      bus_ack   = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_cs_n = 1'b1; buf_valid = 1'b0; buf_rx = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, buf_tx_byte, busy, cmd_err, buf_reset} !== {1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h tx=%h busy=%b err=%b buf_reset=%b, required all 0 and buf_reset=1",
               bus_req, bus_we, bus_addr, bus_wdata, buf_tx_byte, busy, cmd_err, buf_reset);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_at();
    logic [24:0] e;
    logic [24:0] o;
    begin_frame({8'h10, 8'h80, 8'h5A, 8'h00});
    checks++;
    if (buf_length !== 3'd4) begin errors++; $display("FAIL write_len: got %0d required 4", buf_length); end
    checks++;
    if (buf_reset !== 1'b0) begin errors++; $display("FAIL buf_reset_cs_low: got %b required 0", buf_reset); end
    exp_q.push_back({1'b1, 16'h8010, 8'h5A});
    buf_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_req, busy} !== 2'b01) begin errors++; $display("FAIL decode_cycle: req=%b busy=%b required req=0 busy=1", bus_req, busy); end
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL req_latency: bus_req=%b 4 clk after valid, required 1", bus_req);
    end else begin
      o = {bus_we, bus_addr, bus_wdata};
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL write_at_fields: got %h required %h", o, e); end
      repeat (2) @(negedge clk);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
    end
    checks++;
    if ({bus_req, busy} !== 2'b00) begin errors++; $display("FAIL write_done: req=%b busy=%b required 0 0", bus_req, busy); end
    end_frame();
  endtask

  task automatic test_read_at();
    logic ok;
    logic [24:0] o;
    logic [24:0] e;
    begin_frame({8'h00, 8'h10, 8'h80, 8'h20});
    checks++;
    if (buf_length !== 3'd3) begin errors++; $display("FAIL read_len: got %0d required 3", buf_length); end
    exp_q.push_back({1'b0, 16'h8010, 8'h00});
    buf_valid = 1'b1;
    bus_cycle(1, 8'hC3, ok, o);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL read_timeout: no bus_req, required one");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (o[24:8] !== e[24:8]) begin errors++; $display("FAIL read_at_fields: we/addr %h required %h", o[24:8], e[24:8]); end
    end
    checks++;
    if (buf_tx_byte !== 8'hC3) begin errors++; $display("FAIL read_data: tx=%h required c3", buf_tx_byte); end
    end_frame();
    begin_frame(32'h0);
    checks++;
    if (buf_tx_byte !== 8'hC3) begin errors++; $display("FAIL next_miso: tx=%h required c3", buf_tx_byte); end
    end_frame();
  endtask

  task automatic test_ack_ignored();
    bus_rdata = 8'h55;
    bus_ack   = 1'b1;
    @(negedge clk);
    bus_ack   = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_req, busy, buf_tx_byte} !== {1'b0, 1'b0, 8'hC3}) begin
      errors++; $display("FAIL idle_ack: req=%b busy=%b tx=%h required 0 0 c3", bus_req, busy, buf_tx_byte);
    end
  endtask

  // Sends a frame expected to be rejected: checks length 1, exactly one cmd_err, no bus_req.
  task automatic test_invalid_frame(input logic [31:0] rx);
    int errs_seen;
    int reqs_seen;
    begin_frame(rx);
    checks++;
    if (buf_length !== 3'd1) begin errors++; $display("FAIL invalid_len op=%h: got %0d required 1", rx[7:0], buf_length); end
    buf_valid = 1'b1;
    errs_seen = 0;
    reqs_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmd_err === 1'b1) errs_seen++;
      if (bus_req === 1'b1) reqs_seen++;
    end
    checks++;
    if (errs_seen != 1 || reqs_seen != 0) begin
      errors++; $display("FAIL invalid_op %h: cmd_err cycles=%0d req cycles=%0d required 1 and 0", rx[7:0], errs_seen, reqs_seen);
    end
    end_frame();
  endtask

  task automatic test_write_frame(input logic [31:0] rx, input logic [15:0] addr, input logic [2:0] len);
    logic ok;
    logic [24:0] o;
    logic [24:0] e;
    begin_frame(rx);
    checks++;
    if (buf_length !== len) begin errors++; $display("FAIL frame_len op=%h: got %0d required %0d", rx[7:0], buf_length, len); end
    exp_q.push_back({1'b1, addr, rx[15:8]});
    buf_valid = 1'b1;
    bus_cycle(0, 8'h00, ok, o);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL write_timeout op=%h: no bus_req, required one", rx[7:0]);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL write_fields op=%h: got %h required %h", rx[7:0], o, e); end
    end
    end_frame();
  endtask

  task automatic test_autoinc();
`ifdef SPI_CMD_AUTOINC_EN
    test_write_frame({8'hFF, 8'hFF, 8'h11, 8'h00}, 16'hFFFF, 3'd4);
    test_write_frame({8'h00, 8'h00, 8'h22, 8'h40}, 16'h0000, 3'd2);
    test_write_frame({8'h00, 8'h00, 8'h33, 8'h40}, 16'h0001, 3'd2);
`else
    test_write_frame({8'hFF, 8'hFF, 8'h11, 8'h00}, 16'hFFFF, 3'd4);
    test_invalid_frame({8'h00, 8'h00, 8'h22, 8'h40});
    test_invalid_frame({8'h00, 8'h00, 8'h00, 8'h60});
`endif
  endtask

  task automatic test_stall_cs_rise();
    logic ok;
    logic [24:0] e;
    int unstable;
    begin_frame({8'h00, 8'hA0, 8'h99, 8'h00});
    exp_q.push_back({1'b1, 16'hA000, 8'h99});
    buf_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1) ok = 1'b1;
    end
    e = exp_q.pop_front();
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin spi_cs_n = 1'b1; buf_valid = 1'b0; end
      if ({bus_req, busy, bus_we, bus_addr, bus_wdata} !== {2'b11, e}) unstable++;
      @(negedge clk);
    end
    checks++;
    if (!ok || unstable != 0) begin
      errors++; $display("FAIL stall_hold: req seen=%b unstable cycles=%0d required 1 and 0", ok, unstable);
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, busy} !== 2'b00) begin errors++; $display("FAIL stall_done: req=%b busy=%b required 0 0", bus_req, busy); end
    test_write_frame({8'h02, 8'hB0, 8'h5C, 8'h00}, 16'hB002, 3'd4);
  endtask

  task automatic test_reset_mid_bus();
    logic ok;
    begin_frame({8'h00, 8'h10, 8'h80, 8'h20});
    buf_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_bus_timeout: no bus_req, required one"); end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_req, busy, buf_reset, buf_tx_byte} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL reset_mid_bus: req=%b busy=%b buf_reset=%b tx=%h required 0 0 1 00",
                         bus_req, busy, buf_reset, buf_tx_byte);
    end
    @(negedge clk);
    buf_valid = 1'b0;
    spi_cs_n  = 1'b1;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_at();
    test_read_at();
    test_ack_ignored();
    test_invalid_frame(32'h0000_00E0);
    test_write_frame({8'h34, 8'h12, 8'h77, 8'h00}, 16'h1234, 3'd4);
    test_autoinc();
    test_stall_cs_rise();
    test_reset_mid_bus();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
